// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with pending scoreboard.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    // Constant-foldable clog2: smallest w such that 2**w >= depth.
    function automatic int addr_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back bus of the register file: write port, two read ports, reserve port.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();
    localparam int AW = addr_width(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en_a;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic             rd_valid_a;
    logic             rd_pend_a;
    logic             rd_en_b;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_valid_b;
    logic             rd_pend_b;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             rsv_err;
    logic [DEPTH-1:0] pending;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rsv_en, rsv_addr,
        input  rd_data_a, rd_valid_a, rd_pend_a,
        input  rd_data_b, rd_valid_b, rd_pend_b,
        input  rsv_err, pending
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rsv_en, rsv_addr,
        output rd_data_a, rd_valid_a, rd_pend_a,
        output rd_data_b, rd_valid_b, rd_pend_b,
        output rsv_err, pending
    );
endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: write bypass, register-0 masking, and data/valid/pend flops.
module regfile_read_port #(
    parameter int WIDTH   = 16,
    parameter int AW      = 4,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pend_next,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_pend
);
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    logic             pend_d, pend_q;

    always_comb begin
        data_d  = data_q;
        pend_d  = pend_q;
        valid_d = rd_en;
        if (rd_en) begin
            // Register 0 masking takes priority so a dropped write never bypasses.
            if (ZERO_R0 && rd_addr == '0) begin
                data_d = '0;
            end else if (wr_en && wr_addr == rd_addr) begin
                data_d = wr_data;
            end else begin
                data_d = mem_data;
            end
            pend_d = pend_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
    assign rd_pend  = pend_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two bypassed registered read ports and a
// per-register pending scoreboard for multi-cycle producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] pending_d, pending_q;
    logic             rsv_err_d, rsv_err_q;
    logic             wr_drop;
    logic             rsv_drop;

    assign wr_drop  = ZERO_R0 && bus.wr_addr == '0;
    assign rsv_drop = ZERO_R0 && bus.rsv_addr == '0;

    always_comb begin
        mem_d     = mem_q;
        pending_d = pending_q;
        rsv_err_d = 1'b0;
        if (bus.wr_en && !wr_drop) mem_d[bus.wr_addr] = bus.wr_data;
        if (bus.wr_en) pending_d[bus.wr_addr] = 1'b0;
        // Reserve is applied after the write clear: a same-cycle reserve is the newer producer.
        if (bus.rsv_en && !rsv_drop) begin
            rsv_err_d                = pending_q[bus.rsv_addr];
            pending_d[bus.rsv_addr]  = 1'b1;
        end
        if (ZERO_R0) pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q     <= '{default: '0};
            pending_q <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            pending_q <= pending_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    assign bus.pending = pending_q;
    assign bus.rsv_err = rsv_err_q;

    regfile_read_port #(.WIDTH(WIDTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_port_a (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (bus.rd_en_a),
        .rd_addr   (bus.rd_addr_a),
        .mem_data  (mem_q[bus.rd_addr_a]),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .pend_next (pending_d[bus.rd_addr_a]),
        .rd_data   (bus.rd_data_a),
        .rd_valid  (bus.rd_valid_a),
        .rd_pend   (bus.rd_pend_a)
    );

    regfile_read_port #(.WIDTH(WIDTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_port_b (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (bus.rd_en_b),
        .rd_addr   (bus.rd_addr_b),
        .mem_data  (mem_q[bus.rd_addr_b]),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .pend_next (pending_d[bus.rd_addr_b]),
        .rd_data   (bus.rd_data_b),
        .rd_valid  (bus.rd_valid_b),
        .rd_pend   (bus.rd_pend_b)
    );
endmodule
